// File: rtl/dff_share_arbiter_pkg.sv
// Shared types and helpers for the shared-DFF round-robin arbiter.
package dff_share_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/dff_share_arbiter_if.sv
// Requester-side bus of the shared-DFF arbiter: requests, data and the registered grant/Q outputs.
interface dff_share_if
  import dff_share_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int OW = clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] d_in;
  logic [NREQ-1:0]       gnt;
  logic [OW-1:0]         owner;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic                  hold_timeout;

  modport master (
    output req, lock, d_in,
    input  gnt, owner, q, q_valid, hold_timeout
  );

  modport slave (
    input  req, lock, d_in,
    output gnt, owner, q, q_valid, hold_timeout
  );
endinterface

// File: rtl/dff_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching from ptr upward, modulo NREQ.
module rr_pick
  import dff_share_arbiter_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            any_req
);

  // Scan farthest offset first so the nearest requester to ptr is the last write.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        winner  = PW'((int'(ptr) + k) % NREQ);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_share_arbiter.sv
// Shares one WIDTH-bit register among NREQ requesters with round-robin grants
// and bounded locked bursts; the release edge is always a one-cycle bubble.
module dff_share_arbiter
  import dff_share_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  dff_share_if.slave  bus
);

  localparam int PW = clog2(NREQ);
  localparam int CW = clog2(MAX_HOLD + 1);

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             hold_timeout_q, hold_timeout_d;

  logic [PW-1:0]    win;
  logic             any_req;
  logic             own_active;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .winner  (win),
    .any_req (any_req)
  );

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign own_active = bus.req[owner_q] & bus.lock[owner_q];

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    hold_cnt_d     = hold_cnt_q;
    gnt_d          = gnt_q;
    owner_d        = owner_q;
    q_d            = q_q;
    q_valid_d      = 1'b0;
    hold_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << win;
          owner_d   = win;
          q_d       = bus.d_in[int'(win)*WIDTH +: WIDTH];
          q_valid_d = 1'b1;
          if (bus.lock[win]) begin
            state_d    = ST_HOLD;
            hold_cnt_d = CW'(1);
          end else begin
            ptr_d = next_idx(win);
          end
        end else begin
          gnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (own_active && hold_cnt_q < CW'(MAX_HOLD)) begin
          q_d        = bus.d_in[int'(owner_q)*WIDTH +: WIDTH];
          q_valid_d  = 1'b1;
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
          // A lock drop on the limit cycle counts as voluntary, so no timeout then.
          hold_timeout_d = own_active;
          gnt_d          = '0;
          ptr_d          = next_idx(owner_q);
          hold_cnt_d     = '0;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      hold_cnt_q     <= '0;
      gnt_q          <= '0;
      owner_q        <= '0;
      q_q            <= '0;
      q_valid_q      <= 1'b0;
      hold_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      hold_cnt_q     <= hold_cnt_d;
      gnt_q          <= gnt_d;
      owner_q        <= owner_d;
      q_q            <= q_d;
      q_valid_q      <= q_valid_d;
      hold_timeout_q <= hold_timeout_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.owner        = owner_q;
  assign bus.q            = q_q;
  assign bus.q_valid      = q_valid_q;
  assign bus.hold_timeout = hold_timeout_q;

endmodule

// File: doc/dff_share_arbiter.md
Name: dff_share_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit D-flip-flop storage register among NREQ requesters. Each cycle at most one requester's data is captured into the shared register. A requester may lock the register for a bounded burst of consecutive captures. The block sits between the per-channel producers and the common DFF bank; it sequences which D input reaches Q.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data width of the shared register
MAX_HOLD, 8, maximum consecutive captures per locked grant (>=2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester capture request
lock  input  NREQ  per-requester burst/lock request; meaningful only with req
d_in  input  NREQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  registered one-hot grant, all-zero when idle
owner  output  clog2(NREQ)  index of the current/last granted requester
q  output  WIDTH  shared register contents
q_valid  output  1  1-cycle pulse: q was written on the last edge
hold_timeout  output  1  1-cycle pulse: a lock was force-released at MAX_HOLD

Behaviour:
- Reset (asynchronous, any time, including mid-burst): state=IDLE; gnt=0, owner=0, q=0, q_valid=0, hold_timeout=0; rr pointer ptr=0; hold_cnt=0. Takes effect immediately, without a clock edge.
- State machine: IDLE, HOLD.
- Winner selection (combinational): the first i with req[i]=1, searching ptr, ptr+1, ... modulo NREQ.
- IDLE, any req at an edge:
  - gnt<=onehot(winner); owner<=winner; q<=d_in[winner]; q_valid<=1.
  - If lock[winner]=1: state<=HOLD, hold_cnt<=1.
  - Else: state stays IDLE, ptr<=(winner+1) mod NREQ.
  - Latency: req sampled at edge N gives gnt/q/q_valid visible after edge N.
- IDLE, no req: gnt<=0, q_valid<=0, q holds, owner holds.
- HOLD, req[owner]=1 and lock[owner]=1 and hold_cnt<MAX_HOLD:
  - q<=d_in[owner]; q_valid<=1; gnt held; hold_cnt++.
  - Other requesters are ignored.
- HOLD release conditions:
  - req[owner]=0 or lock[owner]=0: voluntary release.
  - hold_cnt==MAX_HOLD: forced release, hold_timeout<=1 for one cycle.
  - On release: gnt<=0, q_valid<=0, no capture, ptr<=(owner+1) mod NREQ, hold_cnt<=0, state<=IDLE.
  - The release edge is a mandatory 1-cycle bubble. The next grant occurs no earlier than the following edge.
- Captures per lock: a burst delivers at most MAX_HOLD captures (the grant edge counts as 1).
- Fairness: a requester holding req continuously is granted within NREQ grants.
- lock without req: ignored.
- hold_cnt width: clog2(MAX_HOLD+1). The counter never wraps.
- Simultaneous events:
  - reset overrides everything.
  - In HOLD, a lock drop and hold_cnt==MAX_HOLD in the same cycle count as voluntary (hold_timeout=0).
- gnt, owner, q, q_valid and hold_timeout are all registered outputs; none are combinational from inputs.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_HOLD) and a clog2 helper function.
- One natural sub-module: rr_pick, a combinational round-robin priority picker (req, ptr -> winner index, any_req), reusable by other arbiters.
- The shared storage register and the FSM stay in dff_share_arbiter.

Test Plan:
- Reset: hold reset=1 with req=4'b1111 -> gnt=0, q=0, q_valid=0. Deassert reset -> the first edge grants requester 0 and q=d_in[0].
- Round-robin: req=4'b1111, lock=0, d_in={8'h44,8'h33,8'h22,8'h11} -> consecutive edges give owner 0,1,2,3,0 and q 11,22,33,44,11, with q_valid=1 every cycle.
- Voluntary burst: req[2]=lock[2]=1 for 3 cycles, then lock[2]=0 -> 3 captures of d_in[2], then 1 bubble cycle (gnt=0, q_valid=0), then the next grant goes to requester 3 if requesting; hold_timeout=0.
- Forced release: MAX_HOLD=8, req[1]=lock[1]=1 held indefinitely, req[0]=1 -> exactly 8 captures from requester 1, hold_timeout pulses once, then requester 2/3/0 (next in order) is granted.
- Mid-burst reset: assert reset asynchronously between edges during HOLD -> gnt, q and q_valid clear immediately. After reset, the grant restarts from ptr=0.
- Sparse requests: req=4'b1000 only, lock=0 -> owner=3 on consecutive edges. Then req=4'b0001 -> owner=0, q=d_in[0].
